// File: rtl/uart_pkg.sv
// Shared UART definitions: receive sequencer states and word-length encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        BRK_WAIT
    } rx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [3:0] data_bits(input logic [1:0] wls);
        case (wls)
            WLS_5:   return 4'd5;
            WLS_6:   return 4'd6;
            WLS_7:   return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for asynchronous serial/modem inputs; resets to mark (1).
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver_ctrl.sv
// UART receive sequencer: start detection, mid-bit shift pulses, frame-check/RBR strobes, break tracking.
module uart_receiver_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       baud_tick,
    input  logic       uart_rxd,
    input  logic       loop_txd,
    input  logic       loop,
    input  logic [1:0] wls,
    input  logic       pen,
    output logic       receive_shift_en,
    output logic       error_check,
    output logic       rx_done,
    output logic       break_detect,
    output logic       rx_busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

    rx_state_e     state, state_d;
    logic [SW-1:0] samp_cnt, samp_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [1:0]    wls_q, wls_d;
    logic          pen_q, pen_d;
    logic          zero_q, zero_d;
    logic          shift_d, check_d, brk_d, busy_d;
    logic          rxs;
    logic          last_bit;

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (pclk),
        .rst (preset),
        .d   (loop ? loop_txd : uart_rxd),
        .q   (rxs)
    );

    assign last_bit = (bit_cnt == 3'(data_bits(wls_q) - 4'd1));

    always_ff @(posedge pclk) begin
        if (preset) begin
            state            <= IDLE;
            samp_cnt         <= '0;
            bit_cnt          <= '0;
            wls_q            <= '0;
            pen_q            <= 1'b0;
            zero_q           <= 1'b1;
            receive_shift_en <= 1'b0;
            error_check      <= 1'b0;
            rx_done          <= 1'b0;
            break_detect     <= 1'b0;
            rx_busy          <= 1'b0;
        end else begin
            state            <= state_d;
            samp_cnt         <= samp_d;
            bit_cnt          <= bit_d;
            wls_q            <= wls_d;
            pen_q            <= pen_d;
            zero_q           <= zero_d;
            receive_shift_en <= shift_d;
            error_check      <= check_d;
            rx_done          <= check_d;
            break_detect     <= brk_d;
            rx_busy          <= busy_d;
        end
    end

    // Outputs are registered from the decisions made here, so every strobe
    // appears one pclk after the tick that caused it.
    always_comb begin
        state_d = state;
        samp_d  = samp_cnt;
        bit_d   = bit_cnt;
        wls_d   = wls_q;
        pen_d   = pen_q;
        zero_d  = zero_q;
        shift_d = 1'b0;
        check_d = 1'b0;
        brk_d   = 1'b0;

        unique case (state)
            IDLE: begin
                if (baud_tick && !rxs) begin
                    state_d = START;
                    samp_d  = '0;
                    wls_d   = wls;
                    pen_d   = pen;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (samp_cnt == HALF_LAST) begin
                        samp_d = '0;
                        if (!rxs) begin
                            state_d = DATA;
                            bit_d   = '0;
                            zero_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        samp_d = samp_cnt + 1'b1;
                    end
                end
            end
            DATA, PARITY, STOP: begin
                if (baud_tick) begin
                    if (samp_cnt == FULL_LAST) begin
                        samp_d  = '0;
                        shift_d = 1'b1;
                        if (rxs) begin
                            zero_d = 1'b0;
                        end
                        if (state == DATA) begin
                            if (last_bit) begin
                                state_d = pen_q ? PARITY : STOP;
                            end else begin
                                bit_d = bit_cnt + 3'd1;
                            end
                        end else if (state == PARITY) begin
                            state_d = STOP;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        samp_d = samp_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                check_d = 1'b1;
                brk_d   = zero_q;
                state_d = zero_q ? BRK_WAIT : IDLE;
            end
            BRK_WAIT: begin
                if (baud_tick && rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = state_d inside {DATA, PARITY, STOP, DONE};
    end

endmodule

// File: tb/tb_uart_receiver_ctrl.sv
// Self-checking bench for uart_receiver_ctrl: vector table, reset/mid-frame sequences, random lines vs frame-level model.
module tb_uart_receiver_ctrl;

    localparam int OS   = 16;
    localparam int HALF = OS / 2;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       loop_txd = 1'b0;
    logic       loop = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       receive_shift_en, error_check, rx_done, break_detect, rx_busy;

    uart_receiver_ctrl #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .pclk             (pclk),
        .preset           (preset),
        .baud_tick        (baud_tick),
        .uart_rxd         (uart_rxd),
        .loop_txd         (loop_txd),
        .loop             (loop),
        .wls              (wls),
        .pen              (pen),
        .receive_shift_en (receive_shift_en),
        .error_check      (error_check),
        .rx_done          (rx_done),
        .break_detect     (break_detect),
        .rx_busy          (rx_busy)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    bit line_q[$];
    int exp_shift[$];
    int exp_done[$];
    bit exp_brk[$];
    int obs_shift[$];
    int obs_done[$];
    bit obs_brk[$];

    int slot_idx = -1;
    int last_tick = -1;
    int cyc = 0;
    int last_shift_cyc = -100;
    bit busy_seen = 1'b0;

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void add_bits(input bit v, input int n);
        repeat (n) line_q.push_back(v);
    endfunction

    function automatic void add_frame(input logic [7:0] data, input int nd, input bit use_par,
                                      input bit par, input int stops);
        add_bits(1'b0, OS);
        for (int i = 0; i < nd; i++) add_bits(data[i], OS);
        if (use_par) add_bits(par, OS);
        add_bits(1'b1, OS * stops);
    endfunction

    // Frame-level view: per-tick line value, start at first low tick, confirm half a bit
    // later, sample every bit period after that; a frame of all-zero samples is a break.
    function automatic void ref_model(input int nd, input bit use_par, input bit dense);
        bit eff[$];
        int n, k, s, t, nsamp;
        bit all0, complete;
        exp_shift.delete();
        exp_done.delete();
        exp_brk.delete();
        eff = line_q;
        if (dense) begin
            eff.push_front(1'b1);
            eff.push_front(1'b1);
            void'(eff.pop_back());
            void'(eff.pop_back());
        end
        n = eff.size();
        nsamp = nd + int'(use_par) + 1;
        k = 0;
        while (k < n) begin
            if (eff[k] == 1'b0) begin
                s = k;
                if (s + HALF >= n) break;
                if (eff[s + HALF]) begin
                    k = s + HALF + 1;
                    continue;
                end
                all0 = 1'b1;
                complete = 1'b1;
                for (int i = 0; i < nsamp; i++) begin
                    t = s + HALF + OS * (i + 1);
                    if (t >= n) begin
                        complete = 1'b0;
                        break;
                    end
                    exp_shift.push_back(t);
                    if (eff[t]) all0 = 1'b0;
                end
                if (!complete) break;
                t = s + HALF + OS * nsamp;
                exp_done.push_back(t);
                exp_brk.push_back(all0);
                k = t + (dense ? 2 : 1);
                if (all0) begin
                    while (k < n && eff[k] == 1'b0) k++;
                    k++;
                end
            end else begin
                k++;
            end
        end
    endfunction

    function automatic void compare_run(input string tag);
        check({tag, " shift_count"}, obs_shift.size(), exp_shift.size());
        for (int i = 0; i < exp_shift.size() && i < obs_shift.size(); i++)
            check($sformatf("%s shift%0d_tick", tag, i), obs_shift[i], exp_shift[i]);
        check({tag, " done_count"}, obs_done.size(), exp_done.size());
        for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++) begin
            check($sformatf("%s done%0d_tick", tag, i), obs_done[i], exp_done[i]);
            check($sformatf("%s done%0d_break", tag, i), int'(obs_brk[i]), int'(exp_brk[i]));
        end
    endfunction

    task automatic run_line(input int slot, input bit use_loop, input int chg_at,
                            input logic [1:0] chg_wls);
        for (int k = 0; k < line_q.size(); k++) begin
            if (k == chg_at) wls = chg_wls;
            if (use_loop) begin
                loop_txd = line_q[k];
                uart_rxd = 1'b1;
            end else begin
                uart_rxd = line_q[k];
                loop_txd = 1'b0;
            end
            for (int c = 0; c < slot; c++) begin
                baud_tick = (c == slot - 1);
                if (c == slot - 1) slot_idx = k;
                @(negedge pclk);
            end
        end
        baud_tick = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    function automatic void clear_obs();
        obs_shift.delete();
        obs_done.delete();
        obs_brk.delete();
        busy_seen = 1'b0;
    endfunction

    function automatic int count_brk();
        int c = 0;
        foreach (obs_brk[i]) c += int'(obs_brk[i]);
        return c;
    endfunction

    always @(posedge pclk) begin
        if (baud_tick) last_tick = slot_idx;
        #1;
        if (rx_busy) busy_seen = 1'b1;
        if (receive_shift_en) begin
            obs_shift.push_back(last_tick);
            last_shift_cyc = cyc;
            check("busy_at_shift", int'(rx_busy), 1);
            check("shift_vs_check_overlap", int'(error_check), 0);
        end
        if (error_check || rx_done || break_detect) begin
            check("rx_done_eq_error_check", int'(rx_done), int'(error_check));
            if (break_detect) check("break_with_done", int'(rx_done), 1);
            if (error_check) begin
                check("check_after_stop_shift", cyc - last_shift_cyc, 1);
                check("busy_low_after_done", int'(rx_busy), 0);
                obs_done.push_back(obs_shift.size() > 0 ? obs_shift[$] : -1);
                obs_brk.push_back(break_detect);
            end
        end
        cyc++;
    end

    typedef struct {
        int         kind;       // 0 frame, 1 glitch, 2 break then frame
        logic [1:0] wls;
        bit         pen;
        logic [7:0] data;
        int         stops;
        bit         use_loop;
        int         chg_at;
        int         exp_shifts;
        int         exp_dones;
        int         exp_breaks;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int nd;
        logic [7:0] mask;
        bit dense;
        int nseg, sel;
        string tag;

        vecs[0] = '{0, 2'b11, 1'b0, 8'hA5, 1, 1'b0, -1, 9, 1, 0};
        vecs[1] = '{0, 2'b00, 1'b1, 8'h15, 2, 1'b0, -1, 7, 1, 0};
        vecs[2] = '{1, 2'b11, 1'b0, 8'h00, 1, 1'b0, -1, 0, 0, 0};
        vecs[3] = '{2, 2'b11, 1'b0, 8'h5A, 1, 1'b0, -1, 18, 2, 1};
        vecs[4] = '{0, 2'b11, 1'b0, 8'hA5, 1, 1'b1, 60, 9, 1, 0};
        vecs[5] = '{0, 2'b10, 1'b1, 8'h3C, 1, 1'b0, -1, 9, 1, 0};
        vecs[6] = '{0, 2'b01, 1'b0, 8'h2A, 1, 1'b0, -1, 7, 1, 0};

        repeat (3) @(negedge pclk);
        check("reset shift_en", int'(receive_shift_en), 0);
        check("reset error_check", int'(error_check), 0);
        check("reset rx_done", int'(rx_done), 0);
        check("reset break", int'(break_detect), 0);
        check("reset busy", int'(rx_busy), 0);
        preset = 1'b0;
        repeat (2) @(negedge pclk);

        for (int r = 0; r < 7; r++) begin
            nd = int'(vecs[r].wls) + 5;
            mask = 8'((9'd1 << nd) - 9'd1);
            line_q.delete();
            add_bits(1'b1, 10);
            case (vecs[r].kind)
                0: add_frame(vecs[r].data, nd, vecs[r].pen, ^(vecs[r].data & mask), vecs[r].stops);
                1: begin add_bits(1'b0, 5); add_bits(1'b1, 20); end
                default: begin
                    add_bits(1'b0, 2 * 10 * OS);
                    add_bits(1'b1, 20);
                    add_frame(vecs[r].data, nd, 1'b0, 1'b0, 1);
                end
            endcase
            add_bits(1'b1, 30);
            wls = vecs[r].wls;
            pen = vecs[r].pen;
            loop = vecs[r].use_loop;
            ref_model(nd, vecs[r].pen, 1'b0);
            clear_obs();
            run_line(4, vecs[r].use_loop, vecs[r].chg_at, 2'b00);
            tag = $sformatf("vec%0d", r);
            compare_run(tag);
            check({tag, " table_shifts"}, obs_shift.size(), vecs[r].exp_shifts);
            check({tag, " table_dones"}, obs_done.size(), vecs[r].exp_dones);
            check({tag, " table_breaks"}, count_brk(), vecs[r].exp_breaks);
            if (vecs[r].exp_shifts > 0 && obs_shift.size() > 0)
                check({tag, " first_shift_tick"}, obs_shift[0], 10 + 24);
            if (vecs[r].kind == 1)
                check({tag, " busy_never"}, int'(busy_seen), 0);
        end

        // Reset during the 4th data bit abandons the frame; the next frame is clean.
        wls = 2'b11; pen = 1'b0; loop = 1'b0;
        line_q.delete();
        add_bits(1'b1, 10);
        add_frame(8'h3C, 8, 1'b0, 1'b0, 1);
        while (line_q.size() > 76) void'(line_q.pop_back());
        ref_model(8, 1'b0, 1'b0);
        clear_obs();
        run_line(4, 1'b0, -1, 2'b00);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        check("midreset shift_en", int'(receive_shift_en), 0);
        check("midreset error_check", int'(error_check), 0);
        check("midreset rx_done", int'(rx_done), 0);
        check("midreset break", int'(break_detect), 0);
        check("midreset busy", int'(rx_busy), 0);
        compare_run("midreset_partial");
        check("midreset partial_shifts", obs_shift.size(), 3);
        repeat (20) @(negedge pclk);
        check("midreset no_done", obs_done.size(), 0);
        line_q.delete();
        add_bits(1'b1, 10);
        add_frame(8'hC3, 8, 1'b0, 1'b0, 1);
        add_bits(1'b1, 30);
        ref_model(8, 1'b0, 1'b0);
        clear_obs();
        run_line(4, 1'b0, -1, 2'b00);
        compare_run("postreset");
        check("postreset shifts", obs_shift.size(), 9);

        // Random lines; the first two runs tick on every pclk.
        for (int run = 0; run < 8; run++) begin
            dense = (run < 2);
            wls = 2'($urandom_range(0, 3));
            pen = 1'($urandom_range(0, 1));
            loop = 1'($urandom_range(0, 1));
            nd = int'(wls) + 5;
            line_q.delete();
            add_bits(1'b1, 10);
            nseg = $urandom_range(2, 5);
            for (int g = 0; g < nseg; g++) begin
                sel = $urandom_range(0, 9);
                if (sel <= 5) begin
                    add_frame(8'($urandom), nd, pen, 1'($urandom), $urandom_range(1, 2));
                    add_bits(1'b1, $urandom_range(0, 12));
                end else if (sel <= 7) begin
                    add_bits(1'b0, $urandom_range(1, 7));
                    add_bits(1'b1, $urandom_range(9, 20));
                end else if (sel == 8) begin
                    repeat ($urandom_range(16, 64)) line_q.push_back(1'($urandom));
                    add_bits(1'b1, 20);
                end else begin
                    add_bits(1'b0, $urandom_range(170, 250));
                    add_bits(1'b1, 5);
                end
            end
            add_bits(1'b1, 180);
            ref_model(nd, pen, dense);
            clear_obs();
            run_line(dense ? 1 : 4, loop, -1, 2'b00);
            compare_run($sformatf("rand%0d", run));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver_ctrl.md
Name: uart_receiver_ctrl

Overview:
Receive-side sequencer for the UART receiver shift block.
- Detects the start bit on the selected serial line (loopback or pad) using 16x oversampling.
- Issues one mid-bit shift-enable pulse per data, parity and first stop bit.
- Then strobes frame checking and the RBR load.
- Flags break frames, and holds off the next start detection until the line returns to mark.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period; must be an even number, 4 or more.
SYNC_STAGES, 2, flops in the serial-input synchroniser; 2 or more.

Ports:
pclk  input  1  UART clock; all logic is on the rising edge.
preset  input  1  reset, synchronous, active-high.
baud_tick  input  1  one-pclk pulse at OVERSAMPLE x baud rate.
uart_rxd  input  1  serial data from the pad.
loop_txd  input  1  transmitter serial output, used in loopback.
loop  input  1  1 selects loop_txd as the serial source.
wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits.
pen  input  1  parity enable.
receive_shift_en  output  1  one-cycle shift pulse to the shift block.
error_check  output  1  one-cycle strobe; the stop bit is at the shift register LSB.
rx_done  output  1  one-cycle strobe: load rsr_data/parity into RBR and set data-ready.
break_detect  output  1  one-cycle strobe with rx_done when the whole frame was 0.
rx_busy  output  1  high from confirmed start bit through DONE.

Behaviour:
- Reset (preset=1 at a pclk edge):
  - state goes to IDLE; all counters go to 0.
  - Synchroniser flops and the zero-tracking flag go to 1.
  - All outputs are 0. Reset mid-frame abandons the frame with no strobes.
- Serial source: loop ? loop_txd : uart_rxd, passed through SYNC_STAGES flops to give rxs.
- Counters:
  - samp_cnt is log2(OVERSAMPLE) bits and advances only on baud_tick.
  - bit_cnt is 3 bits.
- Configuration capture: wls and pen are captured at the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- States and transitions:
  - IDLE: on baud_tick with rxs=0, go to START with samp_cnt=0.
  - START: on each baud_tick, samp_cnt increments. On the tick where samp_cnt=OVERSAMPLE/2-1:
    - rxs=0: go to DATA with samp_cnt=0, bit_cnt=0, rx_busy=1.
    - rxs=1: false start, return to IDLE with no pulses.
  - DATA: on the tick where samp_cnt=OVERSAMPLE-1 (mid-bit):
    - Pulse receive_shift_en for one cycle and wrap samp_cnt to 0.
    - If bit_cnt = wls_q+4, go to PARITY if pen_q, else STOP. Otherwise increment bit_cnt.
  - PARITY: mid-bit pulses receive_shift_en, then go to STOP.
  - STOP: mid-bit pulses receive_shift_en, then go to DONE. Only the first stop bit is sampled; a second stop bit is not checked.
  - DONE (exactly one cycle): error_check=1 and rx_done=1.
    - If the zero flag is set, break_detect=1 and go to BRK_WAIT.
    - Otherwise go to IDLE.
  - BRK_WAIT: stay until baud_tick with rxs=1, then go to IDLE. rx_busy=0 in this state.
- Zero flag:
  - Set to 1 on entering DATA.
  - Cleared on any mid-bit sample with rxs=1 (data, parity or stop).
- Shift count per frame is (wls+5) + pen + 1, ranging from 6 to 10.
- No shift is issued for the start bit.
- Strobe spacing:
  - receive_shift_en pulses are exactly OVERSAMPLE baud_ticks apart.
  - error_check/rx_done come exactly 1 pclk after the stop-bit shift pulse.
- Outputs are registered (Moore-style); receive_shift_en never overlaps error_check.
- Boundary cases:
  - A baud_tick in the DONE cycle is ignored (no counter or state effect).
  - A new start bit immediately after a valid stop is detected from IDLE on the next qualifying baud_tick.
  - If baud_tick is held high continuously, behaviour is still well-defined: one tick per pclk.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP, DONE, BRK_WAIT).
  - WLS_5/6/7/8 constants.
  - Function data_bits(wls) returning wls+5.
- One natural sub-module, uart_sync: a parameterised SYNC_STAGES flop chain with reset value 1, reusable for CTS/DSR.

Test Plan:
- 8N1 frame 0xA5 (wls=11, pen=0), OVERSAMPLE=16 with baud_tick every 4 pclk -> 9 shift pulses spaced 64 pclk apart; the first comes 24 ticks after the falling edge. error_check=rx_done=1 one pclk after the 9th pulse; break_detect=0.
- 5E2 frame 0x15 (wls=00, pen=1) -> exactly 7 shift pulses; rx_busy falls after DONE; no sampling of the second stop bit.
- Glitch: rxd low for 5 baud_ticks, then high -> return to IDLE, zero receive_shift_en pulses, rx_busy stays 0.
- Break: rxd held low for 2 frame times with 8N1 -> 9 pulses; rx_done=error_check=break_detect=1 in one cycle. No new frame until rxd goes high; the next falling edge then starts a frame normally.
- loop=1, uart_rxd tied 1, frame driven on loop_txd -> identical pulse timing to scenario 1. wls changed to 00 mid-frame -> still 9 pulses.
- preset asserted for 1 pclk during the 4th data bit -> all outputs 0 the next cycle, no rx_done. The next full frame is received with the correct pulse count.
